ysyx_22050133_rw_mem_responder: RTL and testbench

//  Responder (slave) end of the unified rw burst channel driven by the L1 cache and the uncached LSU/IFU paths.

---
 rtl/ysyx_22050133_rw_mem_responder_pkg.sv | 14 +
 rtl/ysyx_22050133_rw_mem_responder_burst_addr_gen.sv | 21 ++
 rtl/ysyx_22050133_rw_mem_responder.sv | 132 +++++++++++++
 tb/tb_ysyx_22050133_rw_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050133_rw_mem_responder_pkg.sv
// ysyx_22050133_rw_mem_responder_pkg: shared rw/AXI encodings and responder state type
package ysyx_22050133_rw_mem_responder_pkg;
  localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_1 = 3'b000;
  localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_2 = 3'b001;
  localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_4 = 3'b010;
  localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_8 = 3'b011;
  localparam logic [1:0] ysyx_22050133_AXI_BURST_TYPE_FIXED = 2'b00;
  localparam logic [1:0] ysyx_22050133_AXI_BURST_TYPE_INCR  = 2'b01;
  localparam logic [1:0] ysyx_22050133_AXI_BURST_TYPE_WRAP  = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} rspmem_state_e;
  function automatic logic [63:0] size_mask(input logic [1:0] s);
    return s == 2'd3 ? '1 : (64'd1 << (8 << s)) - 64'd1;
  endfunction
endpackage

// File: rtl/ysyx_22050133_rw_mem_responder_burst_addr_gen.sv
// ysyx_22050133_burst_addr_gen: combinational FIXED/INCR/WRAP next-beat address
module ysyx_22050133_burst_addr_gen
  import ysyx_22050133_rw_mem_responder_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);
  logic [AW-1:0] incr, mask;
  logic wrap_ok;
  always_comb begin
    incr = addr + (AW'(1) << size);
    mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    wrap_ok = burst == ysyx_22050133_AXI_BURST_TYPE_WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    next_addr = burst == ysyx_22050133_AXI_BURST_TYPE_FIXED ? addr : wrap_ok ? (addr & ~mask) | (incr & mask) : incr;
  end
endmodule

// File: rtl/ysyx_22050133_rw_mem_responder.sv
// ysyx_22050133_rw_mem_responder: rw burst responder over a 64-bit word memory; YSYX_22050133_RSPMEM_LATENCY_EN adds per-beat wait states
module ysyx_22050133_rw_mem_responder
  import ysyx_22050133_rw_mem_responder_pkg::*;
#(
  parameter int                     RW_DATA_WIDTH = 64,
  parameter int                     RW_ADDR_WIDTH = 32,
  parameter logic [RW_ADDR_WIDTH-1:0] MEM_BASE    = 32'h80000000,
  parameter int                     MEM_WORDS     = 4096,
  parameter int                     LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rw_addr_valid_i,
  output logic                     rw_addr_ready_o,
  input  logic [RW_ADDR_WIDTH-1:0] rw_addr_i,
  input  logic                     rw_we_i,
  input  logic [7:0]               rw_len_i,
  input  logic [2:0]               rw_size_i,
  input  logic [1:0]               rw_burst_i,
  input  logic                     rw_if_i,
  input  logic                     w_data_valid_i,
  output logic                     w_data_ready_o,
  input  logic [RW_DATA_WIDTH-1:0] w_data_i,
  output logic                     r_data_valid_o,
  input  logic                     r_data_ready_i,
  output logic [RW_DATA_WIDTH-1:0] r_data_o,
  output logic                     r_last_o,
  output logic                     err_o
);
  localparam int IW = $clog2(MEM_WORDS);
  rspmem_state_e state;
  logic [RW_ADDR_WIDTH-1:0] addr_q, next_addr;
  logic [7:0] len_q, cnt;
  logic [1:0] size_q, burst_q, sz;
  logic if_q, in_range, wr_hs, rd_hs, lat_done;
  logic [IW-1:0] idx;
  logic [5:0] sh;
  logic [RW_DATA_WIDTH-1:0] mask;
  logic [RW_DATA_WIDTH-1:0] mem [MEM_WORDS];
  always_comb begin
    sz = rw_size_i > ysyx_22050133_AXI_SIZE_BYTES_8 ? 2'd3 : rw_size_i[1:0];
    in_range = addr_q >= MEM_BASE && addr_q < MEM_BASE + RW_ADDR_WIDTH'(MEM_WORDS * 8);
    idx = IW'((addr_q - MEM_BASE) >> 3);
    sh = {addr_q[2:0], 3'b000};
    mask = size_mask(size_q) << sh;
    wr_hs = state == S_WR && w_data_valid_i && w_data_ready_o;
    rd_hs = r_data_valid_o && r_data_ready_i;
  end
  ysyx_22050133_burst_addr_gen #(.AW(RW_ADDR_WIDTH)) u_addr_gen (
    .addr      (addr_q),
    .size      ({1'b0, size_q}),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );
`ifdef YSYX_22050133_RSPMEM_LATENCY_EN
  localparam bit no_lat = LATENCY == 0;
  logic [7:0] lat;
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || wr_hs || rd_hs) lat <= 8'(LATENCY);
    else if (lat != 8'd0) lat <= lat - 8'd1;
  end
  assign lat_done = lat == 8'd0;
`else
  localparam bit no_lat = 1'b1;
  assign lat_done = 1'b1;
`endif
  // out-of-range beats never touch the array
  always_ff @(posedge clk) begin
    if (!rst && wr_hs && in_range) mem[idx] <= (mem[idx] & ~mask) | ((w_data_i << sh) & mask);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rw_addr_ready_o <= 1'b1;
      w_data_ready_o <= 1'b0;
      r_data_valid_o <= 1'b0;
      r_last_o <= 1'b0;
      r_data_o <= '0;
      err_o <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
      cnt <= '0;
      size_q <= '0;
      burst_q <= '0;
      if_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (rw_addr_valid_i) begin
          state <= rw_we_i ? S_WR : S_RD;
          rw_addr_ready_o <= 1'b0;
          w_data_ready_o <= rw_we_i && no_lat;
          addr_q <= rw_addr_i & ~((RW_ADDR_WIDTH'(1) << sz) - RW_ADDR_WIDTH'(1));
          len_q <= rw_len_i;
          cnt <= rw_len_i;
          size_q <= sz;
          burst_q <= rw_burst_i;
          if_q <= rw_if_i;
        end
        S_WR: if (wr_hs) begin
          err_o <= err_o | !in_range | if_q;
          if (cnt == 8'd0) begin
            state <= S_IDLE;
            w_data_ready_o <= 1'b0;
            rw_addr_ready_o <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
            addr_q <= next_addr;
            w_data_ready_o <= no_lat;
          end
        end else if (lat_done) w_data_ready_o <= 1'b1;
        S_RD: if (rd_hs) begin
          r_data_valid_o <= 1'b0;
          r_last_o <= 1'b0;
          if (cnt == 8'd0) begin
            state <= S_IDLE;
            rw_addr_ready_o <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
            addr_q <= next_addr;
          end
        end else if (!r_data_valid_o && lat_done) begin
          r_data_valid_o <= 1'b1;
          r_last_o <= cnt == 8'd0;
          r_data_o <= in_range ? (mem[idx] >> sh) & size_mask(size_q) : '0;
          err_o <= err_o | !in_range;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22050133_rw_mem_responder.sv
// tb_ysyx_22050133_rw_mem_responder: directed bench for the rw memory responder
module tb_ysyx_22050133_rw_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rw_addr_valid_i = 1'b0, rw_addr_ready_o;
  logic [31:0] rw_addr_i = '0;
  logic rw_we_i = 1'b0;
  logic [7:0] rw_len_i = '0;
  logic [2:0] rw_size_i = '0;
  logic [1:0] rw_burst_i = '0;
  logic rw_if_i = 1'b0;
  logic w_data_valid_i = 1'b0, w_data_ready_o;
  logic [63:0] w_data_i = '0;
  logic r_data_valid_o, r_data_ready_i = 1'b0;
  logic [63:0] r_data_o;
  logic r_last_o, err_o;
  int n_assert = 0;
  int n_fail = 0;
  logic [63:0] wd [16];
  logic [63:0] exp_rd [16];
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [63:0] A0 = 64'h0123456789ABCDEF, A1 = 64'hFEDCBA9876543210;
  localparam logic [63:0] A2 = 64'h0F1E2D3C4B5A6978, A3 = 64'hDEADBEEFCAFEF00D;

  always #5 clk = ~clk;

  ysyx_22050133_rw_mem_responder dut (
    .clk             (clk),
    .rst             (rst),
    .rw_addr_valid_i (rw_addr_valid_i),
    .rw_addr_ready_o (rw_addr_ready_o),
    .rw_addr_i       (rw_addr_i),
    .rw_we_i         (rw_we_i),
    .rw_len_i        (rw_len_i),
    .rw_size_i       (rw_size_i),
    .rw_burst_i      (rw_burst_i),
    .rw_if_i         (rw_if_i),
    .w_data_valid_i  (w_data_valid_i),
    .w_data_ready_o  (w_data_ready_o),
    .w_data_i        (w_data_i),
    .r_data_valid_o  (r_data_valid_o),
    .r_data_ready_i  (r_data_ready_i),
    .r_data_o        (r_data_o),
    .r_last_o        (r_last_o),
    .err_o           (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic we, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    int t;
    t = 0;
    while (!rw_addr_ready_o && t < 50) begin tick(); t++; end
    if (t == 50) chk("addr_ready_timeout", rw_addr_ready_o, 1);
    rw_addr_valid_i = 1'b1;
    rw_addr_i = a;
    rw_we_i = we;
    rw_len_i = len;
    rw_size_i = size;
    rw_burst_i = burst;
    tick();
    rw_addr_valid_i = 1'b0;
    chk("addr_ready_low_after_hs", rw_addr_ready_o, 0);
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    int t;
    addr_phase(a, 1'b1, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      w_data_valid_i = 1'b1;
      w_data_i = wd[i];
      while (!w_data_ready_o && t < 50) begin tick(); t++; end
      if (t == 50) chk("w_ready_timeout", w_data_ready_o, 1);
      tick();
    end
    w_data_valid_i = 1'b0;
  endtask

  task automatic read_burst(input string tag, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int stall);
    int t;
    addr_phase(a, 1'b0, len, size, burst);
    r_data_ready_i = stall == 0;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!r_data_valid_o && t < 50) begin tick(); t++; end
      if (t == 50) chk($sformatf("%s_valid_timeout%0d", tag, i), r_data_valid_o, 1);
      chk($sformatf("%s_data%0d", tag, i), r_data_o, exp_rd[i]);
      chk($sformatf("%s_last%0d", tag, i), r_last_o, i == int'(len));
      for (int s = 0; s < stall; s++) begin
        tick();
        chk($sformatf("%s_hold_valid%0d", tag, i), r_data_valid_o, 1);
        chk($sformatf("%s_hold_data%0d", tag, i), r_data_o, exp_rd[i]);
      end
      r_data_ready_i = 1'b1;
      tick();
      if (stall > 0) r_data_ready_i = 1'b0;
    end
    r_data_ready_i = 1'b0;
    chk({tag, "_no_extra_beat"}, r_data_valid_o, 0);
    chk({tag, "_addr_ready_back"}, rw_addr_ready_o, 1);
    tick();
    chk({tag, "_still_idle"}, r_data_valid_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_addr_ready", rw_addr_ready_o, 1);
    chk("rst_w_ready", w_data_ready_o, 0);
    chk("rst_r_valid", r_data_valid_o, 0);
    chk("rst_r_last", r_last_o, 0);
    chk("rst_r_data", r_data_o, 0);
    chk("rst_err", err_o, 0);

    // 1: INCR 8x8B write then read back
    for (int i = 0; i < 8; i++) begin
      wd[i] = {8{8'((i + 1) * 17)}};
      exp_rd[i] = wd[i];
    end
    write_burst(32'h80000000, 8'd7, 3'd3, INCR);
    chk("t1_w_ready_off", w_data_ready_o, 0);
    read_burst("t1", 32'h80000000, 8'd7, 3'd3, INCR, 0);
    chk("t1_err", err_o, 0);

    // 2: byte write into a cleared word
    wd[0] = 64'h0;
    write_burst(32'h80000000, 8'd0, 3'd3, INCR);
    wd[0] = 64'hAB;
    write_burst(32'h80000005, 8'd0, 3'd0, INCR);
    exp_rd[0] = 64'hAB;
    read_burst("t2b", 32'h80000005, 8'd0, 3'd0, INCR, 0);
    exp_rd[0] = 64'h0000AB0000000000;
    read_burst("t2w", 32'h80000000, 8'd0, 3'd3, INCR, 0);

    // 3: WRAP read starting mid-window
    wd[0] = A0; wd[1] = A1; wd[2] = A2; wd[3] = A3;
    write_burst(32'h80000000, 8'd3, 3'd3, INCR);
    exp_rd[0] = A2; exp_rd[1] = A3; exp_rd[2] = A0; exp_rd[3] = A1;
    read_burst("t3wrap", 32'h80000010, 8'd3, 3'd3, WRAP, 0);
    exp_rd[0] = 64'h76543210; exp_rd[1] = 64'hFEDCBA98;
    read_burst("t3half", 32'h80000008, 8'd1, 3'd2, INCR, 0);
    exp_rd[0] = A3; exp_rd[1] = A3;
    read_burst("t3fixed", 32'h80000018, 8'd1, 3'd3, FIXED, 0);

    // 4: initiator stalls 3 cycles per beat
    exp_rd[0] = A0; exp_rd[1] = A1; exp_rd[2] = A2; exp_rd[3] = A3;
    read_burst("t4stall", 32'h80000000, 8'd3, 3'd3, INCR, 3);
    chk("t4_err", err_o, 0);

    // 5: out-of-range read, sticky error, then a normal burst
    exp_rd[0] = 64'h0;
    read_burst("t5oor", 32'h7FFFFFF8, 8'd0, 3'd3, INCR, 0);
    chk("t5_err_set", err_o, 1);
    exp_rd[0] = A1;
    read_burst("t5ok", 32'h80000008, 8'd0, 3'd3, INCR, 0);
    chk("t5_err_sticky", err_o, 1);

    // 6a: reset during beat 3 of an 8-beat read
    addr_phase(32'h80000000, 1'b0, 8'd7, 3'd3, INCR);
    r_data_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (!r_data_valid_o && t < 50) begin tick(); t++; end
      if (t == 50) chk("t6_valid_timeout", r_data_valid_o, 1);
      if (i < 2) tick();
    end
    r_data_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rd_valid_cleared", r_data_valid_o, 0);
    chk("t6_rd_addr_ready", rw_addr_ready_o, 1);
    chk("t6_rd_last_cleared", r_last_o, 0);
    chk("t6_rd_data_cleared", r_data_o, 0);
    chk("t6_err_cleared", err_o, 0);

    // 6b: reset after two beats of an 8-beat write
    addr_phase(32'h80000000, 1'b1, 8'd7, 3'd3, INCR);
    w_data_valid_i = 1'b1;
    w_data_i = 64'hB0B0B0B0B0B0B0B0;
    tick();
    w_data_i = 64'hB1B1B1B1B1B1B1B1;
    tick();
    w_data_i = 64'hB2B2B2B2B2B2B2B2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    w_data_valid_i = 1'b0;
    chk("t6_wr_ready_cleared", w_data_ready_o, 0);
    chk("t6_wr_addr_ready", rw_addr_ready_o, 1);
    exp_rd[0] = 64'hB0B0B0B0B0B0B0B0; exp_rd[1] = 64'hB1B1B1B1B1B1B1B1;
    exp_rd[2] = A2; exp_rd[3] = A3;
    read_burst("t6rb", 32'h80000000, 8'd3, 3'd3, INCR, 0);
    chk("t6_err_final", err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
